// File: rtl/modos_multicanal.sv
// Bank of N_CH saturating need levels: shared (optionally accelerated) seconds prescaler,
// per-channel tick decay, refill with busy hold window, and zero-level alert.
module modos_multicanal #(
   parameter int N_CH       = 4,
   parameter int LVL_W      = 2,
   parameter int TICK_DIV   = 50_000_000,
   parameter int TEST_SPEED = 10,
   parameter int DECAY_S    = 10,
   parameter int HOLD_S     = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    test,
   input  logic [N_CH-1:0]         entrada,
   input  logic [N_CH-1:0]         activo,
   output logic [N_CH*LVL_W-1:0]   nivel,
   output logic [N_CH-1:0]         senal_5seg,
   output logic [N_CH-1:0]         alerta,
   output logic                    tick
);

   localparam int CW    = $clog2(TICK_DIV);
   localparam int DW    = (DECAY_S > 1) ? $clog2(DECAY_S) : 1;
   localparam int HW    = $clog2(HOLD_S + 1);
   localparam int DIV_T = TICK_DIV / TEST_SPEED;
   localparam logic [LVL_W-1:0] LMAX = '1;

   logic [CW-1:0]    pcnt_q, pcnt_d, div_m1;
   logic             test_q, test_chg;
   logic [N_CH-1:0]  accept;

   logic [LVL_W-1:0] lvl_q  [N_CH];
   logic [LVL_W-1:0] lvl_d  [N_CH];
   logic [DW-1:0]    dcnt_q [N_CH];
   logic [DW-1:0]    dcnt_d [N_CH];
   logic [HW-1:0]    hold_q [N_CH];
   logic [HW-1:0]    hold_d [N_CH];

   assign div_m1   = test ? CW'(DIV_T - 1) : CW'(TICK_DIV - 1);
   assign test_chg = test ^ test_q;
   // A mode change restarts the second so the first accelerated tick is a full period
   assign tick     = ~test_chg & (pcnt_q == div_m1);

   always_comb begin
      pcnt_d = pcnt_q + 1'b1;
      if (test_chg || pcnt_q == div_m1) begin
         pcnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt_q <= '0;
         test_q <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         test_q <= test;
      end
   end

   assign accept = entrada & activo & ~senal_5seg;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         lvl_d[i]  = lvl_q[i];
         dcnt_d[i] = dcnt_q[i];
         hold_d[i] = hold_q[i];
         // Refill outranks a coincident decay step
         if (accept[i]) begin
            if (lvl_q[i] != LMAX) begin
               lvl_d[i] = lvl_q[i] + 1'b1;
            end
            dcnt_d[i] = '0;
            hold_d[i] = HW'(HOLD_S);
         end else if (tick) begin
            if (dcnt_q[i] == DW'(DECAY_S - 1)) begin
               dcnt_d[i] = '0;
               if (lvl_q[i] != '0) begin
                  lvl_d[i] = lvl_q[i] - 1'b1;
               end
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
            if (hold_q[i] != '0) begin
               hold_d[i] = hold_q[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            lvl_q[i]  <= LMAX;
            dcnt_q[i] <= '0;
            hold_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            lvl_q[i]  <= lvl_d[i];
            dcnt_q[i] <= dcnt_d[i];
            hold_q[i] <= hold_d[i];
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_out
      assign nivel[g*LVL_W +: LVL_W] = lvl_q[g];
      assign senal_5seg[g]           = (hold_q[g] != '0);
      assign alerta[g]               = (lvl_q[g] == '0);
   end

endmodule

// File: tb/tb_modos_multicanal.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_modos_multicanal;

   localparam int N_CH = 2, LVL_W = 2, TICK_DIV = 4, TEST_SPEED = 2, DECAY_S = 3, HOLD_S = 2;
   localparam int MAXL = (1 << LVL_W) - 1;

   typedef struct {
      logic [N_CH*LVL_W-1:0] niv;
      logic [N_CH-1:0]       sen;
      logic [N_CH-1:0]       al;
      logic                  tk;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  clk_en = 1'b0;
   logic                  rst, test;
   logic [N_CH-1:0]       ent, act;
   logic [N_CH*LVL_W-1:0] nivel;
   logic [N_CH-1:0]       senal_5seg, alerta;
   logic                  tick;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference state: seconds phase, last sampled test, per-channel level / decay phase / hold seconds left
   int m_pc, m_pt;
   int m_lvl[N_CH], m_dc[N_CH], m_hold[N_CH];

   modos_multicanal #(
      .N_CH(N_CH), .LVL_W(LVL_W), .TICK_DIV(TICK_DIV),
      .TEST_SPEED(TEST_SPEED), .DECAY_S(DECAY_S), .HOLD_S(HOLD_S)
   ) dut (
      .clk(clk), .reset(rst), .test(test), .entrada(ent), .activo(act),
      .nivel(nivel), .senal_5seg(senal_5seg), .alerta(alerta), .tick(tick)
   );

   initial begin
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, e);
      end
   endtask

   function automatic int divof(input logic t);
      return t ? TICK_DIV / TEST_SPEED : TICK_DIV;
   endfunction

   function automatic exp_t snapshot(input logic t);
      exp_t x;
      for (int i = 0; i < N_CH; i++) begin
         x.niv[i*LVL_W +: LVL_W] = m_lvl[i][LVL_W-1:0];
         x.sen[i] = (m_hold[i] > 0);
         x.al[i]  = (m_lvl[i] == 0);
      end
      x.tk = (m_pt == int'(t)) && (m_pc == divof(t) - 1);
      return x;
   endfunction

   task automatic model_reset();
      m_pc = 0;
      m_pt = 0;
      for (int i = 0; i < N_CH; i++) begin
         m_lvl[i] = MAXL; m_dc[i] = 0; m_hold[i] = 0;
      end
   endtask

   // one clock: apply inputs, advance the reference by one second-rule step, queue the prediction
   task automatic step(input logic t, input logic [N_CH-1:0] e, input logic [N_CH-1:0] a);
      int  d;
      bit  tk;
      test = t; ent = e; act = a;
      d  = divof(t);
      tk = (m_pt == int'(t)) && (m_pc == d - 1);
      if (m_pt != int'(t)) m_pc = 0;
      else                 m_pc = (m_pc + 1) % d;
      m_pt = int'(t);
      for (int i = 0; i < N_CH; i++) begin
         if (e[i] && a[i] && m_hold[i] == 0) begin
            m_lvl[i]  = (m_lvl[i] + 1 > MAXL) ? MAXL : m_lvl[i] + 1;
            m_dc[i]   = 0;
            m_hold[i] = HOLD_S;
         end else if (tk) begin
            m_dc[i] = (m_dc[i] + 1) % DECAY_S;
            if (m_dc[i] == 0 && m_lvl[i] > 0) m_lvl[i]--;
            if (m_hold[i] > 0) m_hold[i]--;
         end
      end
      sb.push_back(snapshot(t));
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      exp_t x;
      rst = 1'b1;
      #1;
      chk("rst_nivel", nivel, {(N_CH*LVL_W){1'b1}});
      chk("rst_senal", senal_5seg, 0);
      chk("rst_alerta", alerta, 0);
      chk("rst_tick", tick, 0);
      model_reset();
      x = snapshot(1'b0);
      x.tk = 1'b0;
      sb.push_back(x);
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("nivel", nivel, x.niv);
            chk("senal_5seg", senal_5seg, x.sen);
            chk("alerta", alerta, x.al);
            chk("tick", tick, x.tk);
         end
      end
   end

   initial begin
      logic t;
      logic [N_CH-1:0] e, a;
      rst = 1'b1; test = 1'b0; ent = '0; act = '0;
      #1;
      chk("rst0_nivel", nivel, 4'b1111);
      chk("rst0_senal", senal_5seg, 0);
      chk("rst0_alerta", alerta, 0);
      chk("rst0_tick", tick, 0);
      model_reset();
      clk_en = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;

      // idle decay: 3 -> 2 at 12 cycles, 0 with alert at 36, then stays at 0
      for (int k = 1; k <= 48; k++) begin
         step(1'b0, 2'b00, 2'b11);
         if (k == 11) chk("decay_k11", nivel[1:0], 3);
         if (k == 12) chk("decay_k12", nivel[1:0], 2);
         if (k == 36) begin
            chk("decay_k36", nivel[1:0], 0);
            chk("alert_k36", alerta[0], 1);
         end
         if (k == 48) chk("decay_floor", nivel[1:0], 0);
      end

      // refill coinciding with a decay event at level 1
      do_reset();
      for (int k = 1; k <= 35; k++) step(1'b0, 2'b00, 2'b11);
      chk("pre_coincide", nivel[1:0], 1);
      step(1'b0, 2'b01, 2'b11);
      chk("coincide_ch0", nivel[1:0], 2);
      chk("coincide_ch1", nivel[3:2], 0);
      chk("coincide_busy", senal_5seg, 2'b01);
      step(1'b0, 2'b01, 2'b11);
      chk("busy_ignore", nivel[1:0], 2);
      for (int k = 0; k < 10; k++) step(1'b0, 2'b00, 2'b00);
      step(1'b0, 2'b11, 2'b00);
      step(1'b0, 2'b11, 2'b11);
      for (int k = 0; k < 12; k++) step(1'b0, 2'b00, 2'b11);

      // full-level refill, then accelerated mode, then reset inside a busy window
      do_reset();
      step(1'b0, 2'b10, 2'b11);
      chk("full_refill_lvl", nivel[3:2], 3);
      chk("full_refill_busy", senal_5seg[1], 1);
      for (int k = 0; k < 14; k++) step(1'b0, 2'b00, 2'b11);
      for (int k = 0; k < 20; k++) step(1'b1, 2'b00, 2'b11);
      step(1'b1, 2'b11, 2'b11);
      step(1'b1, 2'b00, 2'b00);
      do_reset();

      for (int k = 0; k < 2500; k++) begin
         t = test;
         if ($urandom_range(49) == 0) t = ~t;
         for (int i = 0; i < N_CH; i++) begin
            e[i] = ($urandom_range(3) == 0);
            a[i] = ($urandom_range(3) != 0);
         end
         if ($urandom_range(399) == 0) begin
            test = t;
            do_reset();
         end else begin
            step(t, e, a);
         end
      end

      @(negedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
